mem_port_scheduler: RTL and testbench

Sequential scheduler that shares the single unified memory port between instruction fetch (instruction-cache refill) and the TLB-lookup stage (data-cache refill and write-back). It replaces combinational pass-through arbitration with a registered grant. Address and write-enable are latched and held stable for the whole memory transaction. Data requests have priority, with a bounded streak so fetch cannot starve, and a watchdog flags a memory that never answers. It sits between the fetch/TLB stages and the memory model.

---
 rtl/mem_port_scheduler.sv | 117 +++++++++++
 tb/tb_mem_port_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_scheduler.sv
// Registered arbiter sharing one memory port between instruction fetch and the
// data (TLB) stage: data priority with a bounded streak, and a stuck-memory watchdog.
module mem_port_scheduler #(
    parameter int addr_width      = 16,
    parameter int max_data_streak = 4,
    parameter int timeout_cycles  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  petitionInstr,
    input  logic [addr_width-1:0] addressInstr,
    input  logic                  petitionDat,
    input  logic [addr_width-1:0] addressDat,
    input  logic                  weDat,
    input  logic                  serviceReadyMem,
    output logic                  petitionMem,
    output logic [addr_width-1:0] addressMem,
    output logic                  weMem,
    output logic                  serviceReadyInstr,
    output logic                  serviceReadyDat,
    output logic                  grantDat,
    output logic                  busy,
    output logic                  error
);

    localparam int streak_w = $clog2(max_data_streak + 1);
    localparam int wd_w     = $clog2(timeout_cycles);
    localparam logic [streak_w-1:0] streak_max = streak_w'(max_data_streak);
    localparam logic [wd_w-1:0]     wd_alarm   = wd_w'(timeout_cycles - 2);
    localparam logic [wd_w-1:0]     wd_sat     = wd_w'(timeout_cycles - 1);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

    state_t                state_q, state_d;
    logic [streak_w-1:0]   streak_q;
    logic [wd_w-1:0]       wd_q;
    logic [addr_width-1:0] addr_q;
    logic                  we_q;
    logic                  error_q;
    logic                  grant_i, grant_d, serving;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d           = state_q;
        grant_i           = 1'b0;
        grant_d           = 1'b0;
        serving           = 1'b0;
        petitionMem       = 1'b0;
        grantDat          = 1'b0;
        busy              = 1'b1;
        serviceReadyInstr = 1'b0;
        serviceReadyDat   = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                // Data wins unless fetch has already waited through a full streak.
                if (petitionDat && !(petitionInstr && streak_q == streak_max)) begin
                    grant_d = 1'b1;
                    state_d = SERVE_D;
                end else if (petitionInstr) begin
                    grant_i = 1'b1;
                    state_d = SERVE_I;
                end
            end
            SERVE_I: begin
                serving           = 1'b1;
                petitionMem       = 1'b1;
                serviceReadyInstr = serviceReadyMem & petitionInstr & ~reset;
                if (serviceReadyMem) state_d = RELEASE;
            end
            SERVE_D: begin
                serving         = 1'b1;
                petitionMem     = 1'b1;
                grantDat        = 1'b1;
                serviceReadyDat = serviceReadyMem & ~reset;
                if (serviceReadyMem) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            streak_q <= '0;
            wd_q     <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                addr_q <= addressDat;
                we_q   <= weDat;
                wd_q   <= '0;
                if (!petitionInstr)               streak_q <= '0;
                else if (streak_q != streak_max)  streak_q <= streak_q + 1'b1;
            end else if (grant_i) begin
                addr_q   <= addressInstr;
                we_q     <= 1'b0;
                wd_q     <= '0;
                streak_q <= '0;
            end else if (serving && !serviceReadyMem) begin
                // Counter holds the number of completed serve cycles; alarm lands on cycle timeout_cycles.
                if (wd_q == wd_alarm) error_q <= 1'b1;
                if (wd_q != wd_sat)   wd_q    <= wd_q + 1'b1;
            end
        end
    end

    assign addressMem = addr_q;
    assign weMem      = we_q;
    assign error      = error_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Randomized and directed bench for mem_port_scheduler, checked cycle by cycle
// against a transaction-level reference model.
module tb_mem_port_scheduler;

    localparam int ADDR_W     = 16;
    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 64;
    localparam int OUT_W      = ADDR_W + 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              petitionInstr, petitionDat, weDat, serviceReadyMem;
    logic [ADDR_W-1:0] addressInstr, addressDat;
    logic              petitionMem, weMem, serviceReadyInstr, serviceReadyDat;
    logic              grantDat, busy, error;
    logic [ADDR_W-1:0] addressMem;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: who owns the port, whether the one-cycle gap is pending, and history.
    int                m_owner;      // 0 none, 1 fetch, 2 data
    bit                m_gap;
    int                m_streak;
    int                m_serve_cycle;
    bit                m_error;
    logic [ADDR_W-1:0] m_addr;
    bit                m_we;

    // Outputs as observed during the most recent cycle.
    logic              o_pm, o_we, o_sri, o_srd, o_gd, o_busy, o_err;
    logic [ADDR_W-1:0] o_addr;

    mem_port_scheduler #(
        .addr_width(ADDR_W), .max_data_streak(MAX_STREAK), .timeout_cycles(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .petitionInstr(petitionInstr), .addressInstr(addressInstr),
        .petitionDat(petitionDat), .addressDat(addressDat), .weDat(weDat),
        .serviceReadyMem(serviceReadyMem),
        .petitionMem(petitionMem), .addressMem(addressMem), .weMem(weMem),
        .serviceReadyInstr(serviceReadyInstr), .serviceReadyDat(serviceReadyDat),
        .grantDat(grantDat), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL time_limit: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "time limit");
    end

    task automatic model_clear();
        m_owner = 0; m_gap = 0; m_streak = 0; m_serve_cycle = 0;
        m_error = 0; m_addr = '0; m_we = 0;
    endtask

    // Runs one clock cycle with the inputs currently driven: compares all outputs with the
    // model, then advances the model by the transaction rules and steps the clock.
    task automatic cycle();
        logic [OUT_W-1:0] got, exp;
        bit               data_wins;
        #2;
        o_pm = petitionMem; o_addr = addressMem; o_we = weMem; o_sri = serviceReadyInstr;
        o_srd = serviceReadyDat; o_gd = grantDat; o_busy = busy; o_err = error;
        got = {o_pm, o_addr, o_we, o_sri, o_srd, o_gd, o_busy, o_err};
        exp = {m_owner != 0, m_addr, m_we,
               m_owner == 1 && serviceReadyMem && petitionInstr && !reset,
               m_owner == 2 && serviceReadyMem && !reset,
               m_owner == 2, m_owner != 0 || m_gap, m_error};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL outputs @%0t: got pm/addr/we/sri/srd/gd/busy/err=%h required %h",
                     $time, got, exp);
        end
        if (reset) begin
            model_clear();
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_owner != 0) begin
            if (serviceReadyMem) begin
                m_owner = 0;
                m_gap   = 1;
            end else begin
                if (m_serve_cycle >= TIMEOUT - 1) m_error = 1;
                m_serve_cycle++;
            end
        end else begin
            data_wins = petitionDat && !(petitionInstr && m_streak == MAX_STREAK);
            if (data_wins) begin
                m_owner = 2; m_addr = addressDat; m_we = weDat; m_serve_cycle = 1;
                m_streak = petitionInstr ? ((m_streak < MAX_STREAK) ? m_streak + 1 : m_streak) : 0;
            end else if (petitionInstr) begin
                m_owner = 1; m_addr = addressInstr; m_we = 0; m_serve_cycle = 1;
                m_streak = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        petitionInstr = 0; petitionDat = 0; weDat = 0; serviceReadyMem = 0;
        addressInstr = '0; addressDat = '0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        serviceReadyMem = 1;
        cycle();
        reset = 0; serviceReadyMem = 0;
        cycle();
        vectors++;
        if ({o_pm, o_addr, o_we, o_gd, o_busy, o_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got %h required 0", {o_pm, o_addr, o_we, o_gd, o_busy, o_err});
        end
    endtask

    task automatic test_instr_read();
        int busy_cnt = 0, pulses = 0, pulse_at = -1;
        addressInstr = 16'h000C;
        for (int i = 0; i < 9; i++) begin
            petitionInstr   = (i <= 4);
            serviceReadyMem = (i == 4);
            cycle();
            busy_cnt += o_busy;
            if (o_sri) begin pulses++; pulse_at = i; end
            if (i == 2) begin
                vectors++;
                if (o_addr !== 16'h000C || o_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL instr_latch: got addr=%h we=%b required addr=000c we=0", o_addr, o_we);
                end
            end
        end
        vectors++;
        if (busy_cnt != 5 || pulses != 1 || pulse_at != 4) begin
            miscompares++;
            $display("FAIL instr_read: got busy=%0d pulses=%0d at=%0d required busy=5 pulses=1 at=4",
                     busy_cnt, pulses, pulse_at);
        end
        idle_inputs();
    endtask

    task automatic test_data_writeback();
        int gd_cnt = 0, srd_cnt = 0;
        petitionDat = 1; addressDat = 16'h0040; weDat = 1;
        cycle();
        addressDat = 16'h1234; weDat = 0;
        for (int i = 1; i <= 3; i++) begin
            serviceReadyMem = (i == 3);
            cycle();
            gd_cnt  += (o_gd && o_we && o_addr == 16'h0040);
            srd_cnt += o_srd;
        end
        serviceReadyMem = 0;
        cycle();
        vectors++;
        if (gd_cnt != 3 || srd_cnt != 1 || o_pm !== 1'b0 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL data_writeback: got grant=%0d pulses=%0d release_pm=%b busy=%b required 3 1 0 1",
                     gd_cnt, srd_cnt, o_pm, o_busy);
        end
        petitionDat = 0;
        cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        string seq = "";
        int    last_grant = -100, bad_spacing = 0;
        logic  prev_pm = 0;
        reset = 1; cycle(); reset = 0;
        petitionInstr = 1; petitionDat = 1; serviceReadyMem = 1;
        for (int i = 0; i < 40 && seq.len() < 10; i++) begin
            addressInstr = ADDR_W'($urandom); addressDat = ADDR_W'($urandom); weDat = 1'($urandom);
            cycle();
            if (o_pm && !prev_pm) begin
                seq = {seq, o_gd ? "D" : "I"};
                if (last_grant >= 0 && i - last_grant != 3) bad_spacing++;
                last_grant = i;
            end
            prev_pm = o_pm;
        end
        vectors++;
        if (seq != "DDDDIDDDDI" || bad_spacing != 0) begin
            miscompares++;
            $display("FAIL starvation: got %s spacing_errors=%0d required DDDDIDDDDI 0", seq, bad_spacing);
        end
        idle_inputs();
        cycle(); cycle();
    endtask

    task automatic test_withdrawn_fetch();
        int pulses = 0;
        logic busy_rel, busy_after;
        petitionInstr = 1; addressInstr = 16'h0ABC;
        cycle();
        cycle();
        petitionInstr = 0; serviceReadyMem = 1;
        cycle();
        pulses += o_sri;
        serviceReadyMem = 0;
        cycle(); busy_rel = o_busy;
        cycle(); busy_after = o_busy;
        vectors++;
        if (pulses != 0 || busy_rel !== 1'b1 || busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL withdrawn_fetch: got pulses=%0d busy_rel=%b busy_idle=%b required 0 1 0",
                     pulses, busy_rel, busy_after);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            if (!petitionInstr || o_sri) petitionInstr = ($urandom_range(0, 2) == 0) && !o_sri;
            else if ($urandom_range(0, 9) == 0) petitionInstr = 0;
            if (!petitionDat || o_srd) begin
                petitionDat = ($urandom_range(0, 2) == 0) && !o_srd;
                weDat       = 1'($urandom);
            end
            addressInstr    = ADDR_W'($urandom);
            addressDat      = ADDR_W'($urandom);
            serviceReadyMem = ($urandom_range(0, 2) == 0);
            cycle();
        end
        reset = 1; idle_inputs(); cycle(); reset = 0;
    endtask

    task automatic test_watchdog_reset();
        int first_err = -1;
        petitionDat = 1; addressDat = 16'h0777; weDat = 1;
        cycle();
        for (int n = 1; n <= 70; n++) begin
            cycle();
            if (o_err && first_err < 0) first_err = n;
        end
        vectors++;
        if (first_err != TIMEOUT || o_err !== 1'b1 || o_gd !== 1'b1) begin
            miscompares++;
            $display("FAIL watchdog: got first_err_cycle=%0d err=%b grant=%b required %0d 1 1",
                     first_err, o_err, o_gd, TIMEOUT);
        end
        reset = 1; serviceReadyMem = 1;
        cycle();
        vectors++;
        if (o_srd !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulse: got serviceReadyDat=%b required 0", o_srd);
        end
        reset = 0; serviceReadyMem = 0; petitionDat = 0;
        cycle();
        vectors++;
        if ({o_pm, o_addr, o_we, o_sri, o_srd, o_gd, o_busy, o_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_serve: got %h required 0",
                     {o_pm, o_addr, o_we, o_sri, o_srd, o_gd, o_busy, o_err});
        end
    endtask

    initial begin
        reset = 1; idle_inputs();
        o_sri = 0; o_srd = 0;
        @(posedge clk);
        #1;
        model_clear();
        test_reset();
        test_instr_read();
        test_data_writeback();
        test_back_to_back();
        test_withdrawn_fetch();
        test_random();
        test_watchdog_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
